regfile_write_scheduler: RTL and testbench

REGFILE_WRITE_SCHEDULER -- requirements
Module: regfile_write_scheduler

---
 rtl/regfile_sched_pkg.sv | 15 +
 rtl/regfile_write_scheduler_rr_arbiter2.sv | 28 ++
 rtl/regfile_write_scheduler.sv | 118 +++++++++++
 tb/tb_regfile_write_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sched_pkg.sv
// Shared types and sizes for the register-file write scheduler.
// Holds the FSM state encoding and the register-file geometry.
package regfile_sched_pkg;

    localparam int WIDTH    = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int CLR_LAST = 31;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_write_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter with an internal 1-bit pointer.
// The pointer moves to the loser whenever a grant is consumed.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (advance && (|grant)) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Merges two write requesters and a zeroing sweep onto one
// register-file write port with registered outputs.
module regfile_write_scheduler #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [WIDTH-1:0]  req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [WIDTH-1:0]  req1_data,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [WIDTH-1:0]  rf_wdata,
    output logic              grant_id,
    output logic [7:0]        wr_count
);

    import regfile_sched_pkg::*;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              advance;
    logic              we_nxt;
    logic [ADDR_W-1:0] waddr_nxt;
    logic [WIDTH-1:0]  wdata_nxt;
    logic              gid_nxt;
    logic [ADDR_W-1:0] sel_addr;
    logic [WIDTH-1:0]  sel_data;

    assign req     = {req1_valid, req0_valid};
    assign advance = (state == ARB) && !clr_start && (|req);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (advance),
        .grant   (grant)
    );

    assign req0_ready = advance && grant[0];
    assign req1_ready = advance && grant[1];
    assign clr_busy   = (state == CLEAR);
    assign sel_addr   = grant[1] ? req1_addr : req0_addr;
    assign sel_data   = grant[1] ? req1_data : req0_data;

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        we_nxt      = 1'b0;
        waddr_nxt   = rf_waddr;
        wdata_nxt   = rf_wdata;
        gid_nxt     = grant_id;
        unique case (state)
            ARB: begin
                if (clr_start) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = ADDR_W'(1);
                    we_nxt      = 1'b1;
                    waddr_nxt   = ADDR_W'(1);
                    wdata_nxt   = '0;
                    gid_nxt     = 1'b0;
                end else if (advance) begin
                    // Writes to x0 are consumed but never reach the file.
                    we_nxt    = (sel_addr != '0);
                    waddr_nxt = sel_addr;
                    wdata_nxt = sel_data;
                    gid_nxt   = grant[1];
                end
            end
            CLEAR: begin
                if (clr_cnt == ADDR_W'(CLR_LAST)) begin
                    state_nxt = ARB;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                    we_nxt      = 1'b1;
                    waddr_nxt   = clr_cnt + ADDR_W'(1);
                    wdata_nxt   = '0;
                    gid_nxt     = 1'b0;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB;
            clr_cnt  <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            grant_id <= 1'b0;
            wr_count <= '0;
        end else begin
            state    <= state_nxt;
            clr_cnt  <= clr_cnt_nxt;
            rf_we    <= we_nxt;
            rf_waddr <= waddr_nxt;
            rf_wdata <= wdata_nxt;
            grant_id <= gid_nxt;
            wr_count <= wr_count + 8'(we_nxt);
        end
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Randomized self-checking bench for regfile_write_scheduler
// against a behavioural arbitration/clear model.
module tb_regfile_write_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        clr_start, clr_busy;
    logic        rf_we, grant_id;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [7:0]  wr_count;

    int checks = 0;
    int errors = 0;

    bit         m_ptr;
    logic [7:0] m_cnt;

    regfile_write_scheduler #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_addr(req1_addr), .req1_data(req1_data),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .grant_id(grant_id), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v0, input logic [4:0] a0,
                         input logic [31:0] d0, input bit v1,
                         input logic [4:0] a1, input logic [31:0] d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    // Winner by the round-robin rule: -1 none, else requester index.
    function automatic int pick(input bit v0, input bit v1);
        if (v0 && v1) return int'(m_ptr);
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m_ptr = 1'b0;
        m_cnt = 8'd0;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        clr_start = 1'b0;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, grant_id, clr_busy, wr_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%0b a=%0d d=%0h g=%0b b=%0b c=%0d required all 0",
                     rf_we, rf_waddr, rf_wdata, grant_id, clr_busy, wr_count);
        end
        tick();
        rst_n = 1'b1;
        m_ptr = 1'b0;
        m_cnt = 8'd0;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %0b%0b required 00", req1_ready, req0_ready);
        end
    endtask

    task automatic test_single();
        drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got %0b%0b required 01", req1_ready, req0_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        m_ptr = 1'b1;
        m_cnt = 8'd1;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF ||
            grant_id !== 1'b0 || wr_count !== 8'd1) begin
            errors++;
            $display("FAIL single_write: got we=%0b a=%0d d=%0h g=%0b c=%0d required 1/5/deadbeef/0/1",
                     rf_we, rf_waddr, rf_wdata, grant_id, wr_count);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: got we=%0b required 0", rf_we);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            drive(1, 5'(10 + i), d, 1, 5'(20 + i), ~d);
            #1;
            checks++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %0b%0b", i, req1_ready, req0_ready);
            end
            tick();
            m_cnt++;
            checks++;
            if (rf_we !== 1'b1 || grant_id !== 1'(i % 2) || wr_count !== m_cnt ||
                rf_waddr !== ((i % 2 == 0) ? 5'(10 + i) : 5'(20 + i)) ||
                rf_wdata !== ((i % 2 == 0) ? d : ~d)) begin
                errors++;
                $display("FAIL b2b_write[%0d]: got we=%0b g=%0b a=%0d c=%0d required we=1 g=%0d c=%0d",
                         i, rf_we, grant_id, rf_waddr, wr_count, i % 2, m_cnt);
            end
        end
        m_ptr = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_zero_addr();
        drive(0, 0, 0, 1, 5'd0, 32'h1234);
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready: got %0b required 1", req1_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        m_ptr = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || wr_count !== m_cnt || grant_id !== 1'b1) begin
            errors++;
            $display("FAIL zero_write: got we=%0b c=%0d g=%0b required 0/%0d/1",
                     rf_we, wr_count, grant_id, m_cnt);
        end
    endtask

    task automatic test_clear();
        drive(1, 5'd7, 32'h55, 0, 0, 0);
        clr_start = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_ready0: got %0b required 0", req0_ready);
        end
        tick();
        clr_start = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            m_cnt++;
            checks++;
            if (clr_busy !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'(k) ||
                rf_wdata !== 32'd0 || grant_id !== 1'b0 || req0_ready !== 1'b0 ||
                wr_count !== m_cnt) begin
                errors++;
                $display("FAIL clr_sweep[%0d]: got b=%0b we=%0b a=%0d d=%0h r=%0b c=%0d required c=%0d",
                         k, clr_busy, rf_we, rf_waddr, rf_wdata, req0_ready, wr_count, m_cnt);
            end
            clr_start = (k == 5);
            tick();
        end
        clr_start = 1'b0;
        checks++;
        if (clr_busy !== 1'b0 || rf_we !== 1'b0 || req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_exit: got b=%0b we=%0b r=%0b required 0/0/1",
                     clr_busy, rf_we, req0_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        m_ptr = 1'b1;
        m_cnt++;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h55 || wr_count !== m_cnt) begin
            errors++;
            $display("FAIL clr_after: got we=%0b a=%0d d=%0h c=%0d required 1/7/55/%0d",
                     rf_we, rf_waddr, rf_wdata, wr_count, m_cnt);
        end
        tick();
    endtask

    task automatic test_reset_in_clear();
        int bad;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        checks++;
        if (rf_waddr !== 5'd10 || clr_busy !== 1'b1) begin
            errors++;
            $display("FAIL rclr_at10: got a=%0d b=%0b required 10/1", rf_waddr, clr_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, grant_id, clr_busy, wr_count} !== '0) begin
            errors++;
            $display("FAIL rclr_async: got we=%0b a=%0d b=%0b c=%0d required all 0",
                     rf_we, rf_waddr, clr_busy, wr_count);
        end
        tick();
        drive(1, 5'd3, 32'hA5A5, 0, 0, 0);
        rst_n = 1'b1;
        m_ptr = 1'b0;
        m_cnt = 8'd0;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL rclr_ready: got %0b required 1", req0_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        m_ptr = 1'b1;
        m_cnt = 8'd1;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || wr_count !== 8'd1) begin
            errors++;
            $display("FAIL rclr_first: got we=%0b a=%0d c=%0d required 1/3/1",
                     rf_we, rf_waddr, wr_count);
        end
        bad = 0;
        for (int k = 0; k < 35; k++) begin
            tick();
            if (rf_we !== 1'b0 || clr_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || wr_count !== 8'd1) begin
            errors++;
            $display("FAIL rclr_quiet: got %0d stray cycles c=%0d required 0 and 1", bad, wr_count);
        end
    endtask

    // Random traffic with x0 writes and idle cycles.
    task automatic test_random(input int n, input bit busy);
        bit v0, v1;
        logic [4:0] a0, a1, ea;
        logic [31:0] d0, d1, ed;
        int w;
        for (int i = 0; i < n; i++) begin
            v0 = busy ? 1'b1 : 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            a0 = busy ? 5'($urandom_range(1, 31)) : 5'($urandom_range(0, 31));
            a1 = busy ? 5'($urandom_range(1, 31)) : 5'($urandom_range(0, 31));
            d0 = $urandom;
            d1 = $urandom;
            drive(v0, a0, d0, v1, a1, d1);
            w = pick(v0, v1);
            #1;
            checks++;
            if (req0_ready !== (w == 0) || req1_ready !== (w == 1)) begin
                errors++;
                $display("FAIL rnd_ready[%0d]: got %0b%0b winner %0d", i, req1_ready, req0_ready, w);
            end
            tick();
            if (w >= 0) begin
                ea = (w == 0) ? a0 : a1;
                ed = (w == 0) ? d0 : d1;
                if (ea != 0) m_cnt++;
                m_ptr = (w == 0);
                checks++;
                if (rf_we !== (ea != 0) || rf_waddr !== ea || rf_wdata !== ed ||
                    grant_id !== 1'(w) || wr_count !== m_cnt) begin
                    errors++;
                    $display("FAIL rnd_write[%0d]: got we=%0b a=%0d d=%0h g=%0b c=%0d required a=%0d d=%0h g=%0d c=%0d",
                             i, rf_we, rf_waddr, rf_wdata, grant_id, wr_count, ea, ed, w, m_cnt);
                end
            end else begin
                checks++;
                if (rf_we !== 1'b0 || wr_count !== m_cnt) begin
                    errors++;
                    $display("FAIL rnd_idle[%0d]: got we=%0b c=%0d required 0/%0d", i, rf_we, wr_count, m_cnt);
                end
            end
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_wrap();
        do_reset();
        test_random(256, 1'b1);
        checks++;
        if (wr_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap: got c=%0d required 0", wr_count);
        end
        tick();
    endtask

    initial begin
        clr_start = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_addr();
        test_clear();
        test_reset_in_clear();
        test_random(300, 1'b0);
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
